// File: rtl/q_sys_fifo_pkg.sv
// Shared constants and FSM state type for the q_sys input stream FIFO.
package q_sys_fifo_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF    = 512;
  localparam int unsigned AW_DEF       = 9;
  localparam int unsigned AFULL_TH_DEF = 480;
  localparam int unsigned FILL_W       = 10;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    PREFETCH = 2'd1,
    VALID    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/q_sys_fifo_ram.sv
// Simple dual-port RAM with registered read and no reset; maps onto block RAM.
module q_sys_fifo_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 9
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/q_sys_in_stream_fifo.sv
// FWFT input FIFO for the 32-bit sample stream: Avalon-ST sink/source,
// registered occupancy for the fifo-used PIO, almost_full and sticky overflow.
module q_sys_in_stream_fifo
  import q_sys_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned AFULL_TH = AFULL_TH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [FILL_W-1:0] fill_level,
  output logic              almost_full,
  output logic              overflow
);

  fifo_state_e       state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       ram_cnt_q, ram_cnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic              byp_q, byp_d;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] head_word;
  logic              wr_en;
  logic              pop;
  logic              rd_issue;

  // RAM is addressed with the next read pointer so its output already holds
  // the word at rd_ptr_q; a write landing on that slot the same edge is
  // forwarded through byp_* instead of the stale RAM value.
  q_sys_fifo_ram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata)
  );

  assign head_word = byp_q ? byp_data_q : ram_rdata;

  always_comb begin
    wr_en    = in_valid && in_ready_q && !clear;
    pop      = out_valid_q && out_ready && !clear;
    rd_issue = !clear && (ram_cnt_q != '0) &&
               ((state_q == EMPTY) || ((state_q == VALID) && pop));

    state_d = state_q;
    case (state_q)
      EMPTY:    if (rd_issue) state_d = PREFETCH;
      PREFETCH: state_d = VALID;
      VALID:    if (pop && !rd_issue) state_d = EMPTY;
      default:  state_d = EMPTY;
    endcase

    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    rd_ptr_d  = rd_ptr_q + AW'(rd_issue);
    ram_cnt_d = ram_cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_issue);
    fill_d    = fill_q + FILL_W'(wr_en) - FILL_W'(pop);
    ovf_d     = ovf_q || (in_valid && !in_ready_q);

    if (clear) begin
      state_d   = EMPTY;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      fill_d    = '0;
      ovf_d     = 1'b0;
    end

    out_valid_d = (state_d == VALID);
    in_ready_d  = 32'(fill_d) < DEPTH;
    afull_d     = 32'(fill_d) >= AFULL_TH;
    byp_d       = wr_en && (wr_ptr_q == rd_ptr_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      fill_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
      byp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      fill_q      <= fill_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      afull_q     <= afull_d;
      ovf_q       <= ovf_d;
      byp_q       <= byp_d;
    end
  end

  always_ff @(posedge clk) begin
    byp_data_q <= in_data;
    if (rd_issue) begin
      out_data_q <= head_word;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign fill_level  = fill_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_q_sys_in_stream_fifo.sv
// Bench for q_sys_in_stream_fifo: vector table, directed corner sequences and
// randomized traffic scored against a queue-based model of the FIFO contents.
module tb_q_sys_in_stream_fifo;

  localparam int DEPTH    = 512;
  localparam int AFULL_TH = 480;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [9:0]  fill_level;
  logic        almost_full;
  logic        overflow;

  q_sys_in_stream_fifo #(
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .AW       (9),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .fill_level  (fill_level),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mq [$];
  logic        m_ovf;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic [9:0]  e_fill;
    logic        e_ov;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clear     = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic clr);
    logic ov_s, acc, pp;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
    chk("fill_level", 32'(fill_level), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL_TH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    ov_s = out_valid;
    if (ov_s && mq.size() == 0) chk("out_valid_while_empty", 32'(ov_s), 32'd0);
    pp = ov_s && ordy && !clr;
    if (pp && mq.size() != 0) chk("out_data", out_data, mq[0]);
    acc = iv && !clr && (mq.size() < DEPTH);
    @(posedge clk);
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (pp && mq.size() != 0) void'(mq.pop_front());
      if (acc) mq.push_back(d);
      if (iv && !acc) m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic wait_ovalid(input int max_cyc, input string nm);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < max_cyc) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      k++;
    end
    chk(nm, 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while (mq.size() != 0 && k < max_cyc) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      k++;
    end
    chk("drained fill_level", 32'(fill_level), 32'd0);
    chk("drained out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] seq;
    logic        iv, ordy, clr;

    tbl[0]  = '{1'b1, 32'h1, 1'b0, 10'd1, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h2, 1'b0, 10'd2, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 32'h3, 1'b0, 10'd3, 1'b1, 32'h1};
    tbl[3]  = '{1'b0, 32'h0, 1'b0, 10'd3, 1'b1, 32'h1};
    tbl[4]  = '{1'b0, 32'h0, 1'b1, 10'd2, 1'b1, 32'h2};
    tbl[5]  = '{1'b0, 32'h0, 1'b1, 10'd1, 1'b1, 32'h3};
    tbl[6]  = '{1'b0, 32'h0, 1'b1, 10'd0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'hA, 1'b1, 10'd1, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0, 1'b1, 10'd1, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0, 1'b1, 10'd1, 1'b1, 32'hA};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 10'd1, 1'b1, 32'hA};
    tbl[11] = '{1'b0, 32'h0, 1'b1, 10'd0, 1'b0, 32'h0};

    // Reset and idle
    do_reset();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Vector table: first-write latency, FWFT order, back-to-back pops
    for (int i = 0; i < 12; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      clear     = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d fill_level", i), 32'(fill_level), 32'(tbl[i].e_fill));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("vec%0d out_data", i), out_data, tbl[i].e_data);
    end

    // Fill to capacity, almost_full threshold, overflow on extra write
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == AFULL_TH - 1) chk("almost_full below threshold", 32'(almost_full), 32'd0);
      if (i == AFULL_TH) chk("almost_full at threshold", 32'(almost_full), 32'd1);
    end
    chk("full fill_level", 32'(fill_level), 32'd512);
    chk("full in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'd513, 1'b0, 1'b0);
    chk("overflow set", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("overflow sticky", 32'(overflow), 32'd1);

    // Asynchronous reset between clock edges, mid-stream
    in_valid  = 1'b1;
    in_data   = 32'hDEAD0000;
    out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst fill_level", 32'(fill_level), 32'd0);
    chk("async rst almost_full", 32'(almost_full), 32'd0);
    chk("async rst overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    chk("held rst fill_level", 32'(fill_level), 32'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'h6000_0000 + 32'(i), 1'b0, 1'b0);
    wait_ovalid(8, "post-reset out_valid");
    chk("post-reset head", out_data, 32'h6000_0001);
    drain(50);

    // Steady state of 5 words with continuous streaming across pointer wrap
    do_reset();
    seq = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, seq, 1'b0, 1'b0);
      seq++;
    end
    wait_ovalid(8, "steady start out_valid");
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b1, seq, 1'b1, 1'b0);
      seq++;
      chk("steady fill_level", 32'(fill_level), 32'd5);
      chk("steady out_valid", 32'(out_valid), 32'd1);
    end
    drain(50);

    // Clear at half-full with same-cycle write and pop
    do_reset();
    for (int i = 0; i < 256; i++) cycle(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h1111_1111, 1'b1, 1'b1);
    chk("clear fill_level", 32'(fill_level), 32'd0);
    chk("clear out_valid", 32'(out_valid), 32'd0);
    chk("clear overflow", 32'(overflow), 32'd0);
    cycle(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    wait_ovalid(8, "after clear out_valid");
    chk("after clear head", out_data, 32'hCAFE_F00D);
    drain(50);

    // Randomized traffic: write-heavy phase reaching full, then balanced
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) begin
        iv   = ($urandom_range(0, 99) < 80);
        ordy = ($urandom_range(0, 99) < 25);
      end else begin
        iv   = ($urandom_range(0, 99) < 50);
        ordy = ($urandom_range(0, 99) < 60);
      end
      clr = ($urandom_range(0, 399) == 0);
      cycle(iv, $urandom, ordy, clr);
    end
    drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
